// File: rtl/aq_rtu_dbg_halt_ctrl.sv
// Retire-side debug halt control: trigger/pending/haltreq arbitration, drain, debug mode.
// Optional single-step support is enabled by defining AQ_RTU_DBG_STEP_EN.
module aq_rtu_dbg_halt_ctrl #(
  parameter int HALT_INFO_W = 22,
  parameter int DRAIN_CNT_W = 4
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  input  logic                   iu_rtu_retire_vld,
  input  logic [HALT_INFO_W-1:0] iu_rtu_retire_halt_info,
  input  logic                   iu_rtu_retire_mret,
  input  logic                   iu_rtu_retire_sret,
  input  logic                   dtu_rtu_pending_halt,
  input  logic [3:0]             dtu_rtu_cause,
  input  logic                   had_rtu_halt_req,
  input  logic                   had_rtu_resume_req,
  input  logic                   lsu_rtu_idle,
`ifdef AQ_RTU_DBG_STEP_EN
  input  logic                   had_rtu_step_en,
`endif
  output logic                   rtu_dtu_retire_vld,
  output logic [HALT_INFO_W-1:0] rtu_dtu_retire_halt_info,
  output logic                   rtu_dtu_retire_mret,
  output logic                   rtu_dtu_retire_sret,
  output logic                   rtu_dtu_halt_ack,
  output logic                   rtu_dtu_pending_ack,
  output logic                   rtu_yy_xx_dbgon,
  output logic                   rtu_ifu_flush,
  output logic                   rtu_cp0_bkpt_expt,
  output logic [2:0]             rtu_had_dbg_cause,
  output logic                   rtu_had_dbg_ack
);

  typedef enum logic [1:0] {IDLE, WAIT_AFTER, DRAIN, DBG} state_e;

  // Last drain cycle index: drain lasts at most 2^DRAIN_CNT_W-1 cycles.
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'((1 << DRAIN_CNT_W) - 2);

  state_e                   state_q, state_d;
  logic [DRAIN_CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]               cause_q, cause_d;
  logic                     trig_q, trig_d;
  logic                     rvld_q, rvld_d;
  logic [HALT_INFO_W-1:0]   rinfo_q, rinfo_d;
  logic                     rmret_q, rmret_d;
  logic                     rsret_q, rsret_d;

  logic hit, act_dbg, timing_after;
  logic flush, bkpt, pend_ack, halt_ack, kill_retire;
  logic unused_cause;

  assign unused_cause = ^dtu_rtu_cause;

  assign hit          = iu_rtu_retire_vld & (|iu_rtu_retire_halt_info[19:0]);
  assign act_dbg      = iu_rtu_retire_halt_info[21];
  assign timing_after = iu_rtu_retire_halt_info[20];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cause_d     = cause_q;
    trig_d      = trig_q;
    flush       = 1'b0;
    bkpt        = 1'b0;
    pend_ack    = 1'b0;
    halt_ack    = 1'b0;
    kill_retire = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit && act_dbg && !timing_after) begin
          flush       = 1'b1;
          kill_retire = 1'b1;
          state_d     = DRAIN;
          cause_d     = 3'd2;
          trig_d      = 1'b1;
        end else if (hit && act_dbg) begin
          state_d = WAIT_AFTER;
          cause_d = 3'd2;
          trig_d  = 1'b1;
        end else if (hit) begin
          // Breakpoint exception masks pending/haltreq for this cycle only.
          bkpt  = 1'b1;
          flush = 1'b1;
        end else if (dtu_rtu_pending_halt && iu_rtu_retire_vld) begin
          pend_ack = 1'b1;
          flush    = 1'b1;
          state_d  = DRAIN;
          cause_d  = 3'd2;
          trig_d   = 1'b0;
        end else if (had_rtu_halt_req) begin
          flush   = 1'b1;
          state_d = DRAIN;
          cause_d = 3'd3;
          trig_d  = 1'b0;
        end
`ifdef AQ_RTU_DBG_STEP_EN
        else if (had_rtu_step_en && iu_rtu_retire_vld) begin
          flush   = 1'b1;
          state_d = DRAIN;
          cause_d = 3'd4;
          trig_d  = 1'b0;
        end
`endif
      end
      WAIT_AFTER: begin
        flush   = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (lsu_rtu_idle || (cnt_q == DRAIN_LAST)) begin
          state_d  = DBG;
          cnt_d    = '0;
          halt_ack = trig_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DBG: begin
        if (had_rtu_resume_req) begin
          state_d = IDLE;
          cause_d = 3'd0;
          trig_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    rvld_d  = iu_rtu_retire_vld & ~kill_retire & (state_q != DBG);
    rinfo_d = rvld_d ? iu_rtu_retire_halt_info : '0;
    rmret_d = rvld_d & iu_rtu_retire_mret;
    rsret_d = rvld_d & iu_rtu_retire_sret;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cause_q <= 3'd0;
      trig_q  <= 1'b0;
      rvld_q  <= 1'b0;
      rinfo_q <= '0;
      rmret_q <= 1'b0;
      rsret_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      trig_q  <= trig_d;
      rvld_q  <= rvld_d;
      rinfo_q <= rinfo_d;
      rmret_q <= rmret_d;
      rsret_q <= rsret_d;
    end
  end

  // Same-cycle pulses are forced low while reset is asserted.
  assign rtu_ifu_flush            = flush & cpurst_b;
  assign rtu_cp0_bkpt_expt        = bkpt & cpurst_b;
  assign rtu_dtu_pending_ack      = pend_ack & cpurst_b;
  assign rtu_dtu_halt_ack         = halt_ack & cpurst_b;
  assign rtu_yy_xx_dbgon          = (state_q == DBG);
  assign rtu_had_dbg_ack          = (state_q == DBG);
  assign rtu_had_dbg_cause        = cause_q;
  assign rtu_dtu_retire_vld       = rvld_q;
  assign rtu_dtu_retire_halt_info = rinfo_q;
  assign rtu_dtu_retire_mret      = rmret_q;
  assign rtu_dtu_retire_sret      = rsret_q;

endmodule
